conv_window_sched: RTL

//  Sequencer for the two-operand 3x3 convolution datapath (9 registered multipliers + registered adder tree).

---
 rtl/conv_window_sched_pkg.sv | 19 +
 rtl/conv_window_sched_if.sv | 38 +++
 rtl/conv_window_sched_win_raster_cnt.sv | 43 ++++
 rtl/conv_window_sched.sv | 126 ++++++++++++
 4 files changed

// File: rtl/conv_window_sched_pkg.sv
// Shared constants and state encoding for the 3x3 convolution window sequencer.
package conv_window_sched_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int KSIZE  = 3;
  localparam int KTAPS  = KSIZE * KSIZE;
  localparam int KIDX_W = $clog2(KTAPS + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_CONV  = 3'd2,
    ST_CAPT  = 3'd3,
    ST_OUT   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/conv_window_sched_if.sv
// Bundle of control, image RAM, datapath and result-stream signals of the window sequencer.
// Result stream: a beat transfers on a rising edge where out_valid && out_ready; once raised,
// out_valid stays high and out_data/out_addr stay stable until that edge.
interface conv_window_sched_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = conv_window_sched_pkg::DATA_W,
  parameter int ACC_W  = conv_window_sched_pkg::ACC_W
);
  import conv_window_sched_pkg::*;

  logic                      start;
  logic                      busy;
  logic                      done;
  logic                      pix_rd;
  logic [ADDR_W-1:0]         pix_addr;
  logic [DATA_W-1:0]         pix_data;
  logic [KTAPS*DATA_W-1:0]   win;
  logic                      conv_en;
  logic [ACC_W-1:0]          conv_result;
  logic                      out_valid;
  logic                      out_ready;
  logic [ACC_W-1:0]          out_data;
  logic [ADDR_W-1:0]         out_addr;
  state_t                    dbg_state;

  modport master (
    input  start, pix_data, conv_result, out_ready,
    output busy, done, pix_rd, pix_addr, win, conv_en,
           out_valid, out_data, out_addr, dbg_state
  );

  modport slave (
    output start, pix_data, conv_result, out_ready,
    input  busy, done, pix_rd, pix_addr, win, conv_en,
           out_valid, out_data, out_addr, dbg_state
  );

endinterface

// File: rtl/conv_window_sched_win_raster_cnt.sv
// Output-map raster position: walks (orow, ocol) over the valid 3x3 window origins.
module win_raster_cnt #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] orow,
  output logic [ADDR_W-1:0] ocol,
  output logic              last_win,
  output logic [ADDR_W-1:0] out_addr
);
  import conv_window_sched_pkg::*;

  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_W - 3);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(IMG_H - 3);
  localparam logic [ADDR_W-1:0] OUT_W    = ADDR_W'(IMG_W - 2);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      orow <= '0;
      ocol <= '0;
    end else if (clear) begin
      orow <= '0;
      ocol <= '0;
    end else if (advance) begin
      if (ocol == COL_LAST) begin
        ocol <= '0;
        orow <= orow + ONE;
      end else begin
        ocol <= ocol + ONE;
      end
    end
  end

  assign last_win = (orow == ROW_LAST) && (ocol == COL_LAST);
  assign out_addr = orow * OUT_W + ocol;

endmodule

// File: rtl/conv_window_sched.sv
// Raster sequencer for the 3x3 convolution datapath: fetches each window from a 1-port
// image RAM, steps the 2-stage datapath, and streams the sums with their output addresses.
module conv_window_sched #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int ADDR_W = 10,
  parameter int DATA_W = conv_window_sched_pkg::DATA_W,
  parameter int ACC_W  = conv_window_sched_pkg::ACC_W
) (
  input logic               clk,
  input logic               rst_n,
  conv_window_sched_if.master bus
);
  import conv_window_sched_pkg::*;

  if (IMG_W < 3 || IMG_H < 3 || (IMG_W * IMG_H) > (1 << ADDR_W)) begin : g_param_err
    $error("conv_window_sched: illegal IMG_W/IMG_H/ADDR_W combination");
  end

  localparam logic [KIDX_W-1:0] K_DRAIN   = KIDX_W'(KTAPS);
  localparam logic [KIDX_W-1:0] CONV_LAST = KIDX_W'(1);
  localparam logic [ADDR_W-1:0] IMG_W_A   = ADDR_W'(IMG_W);

  state_t                      state_q, state_d;
  logic [KIDX_W-1:0]           k_q, cap_k_q;
  logic                        rd_pend_q;
  logic [KTAPS-1:0][DATA_W-1:0] win_q;
  logic [ACC_W-1:0]            out_data_q;
  logic [ADDR_W-1:0]           out_addr_q;
  logic                        ras_clear, ras_adv, last_win, pix_rd;
  logic [ADDR_W-1:0]           orow, ocol, ras_addr, r_off, c_off, pix_addr;

  win_raster_cnt #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W)
  ) u_raster (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (ras_clear),
    .advance (ras_adv),
    .orow    (orow),
    .ocol    (ocol),
    .last_win(last_win),
    .out_addr(ras_addr)
  );

  always_comb begin
    state_d   = state_q;
    ras_clear = 1'b0;
    ras_adv   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d   = ST_FETCH;
          ras_clear = 1'b1;
        end
      end
      ST_FETCH: if (k_q == K_DRAIN) state_d = ST_CONV;
      ST_CONV:  if (k_q == CONV_LAST) state_d = ST_CAPT;
      ST_CAPT:  state_d = ST_OUT;
      ST_OUT: begin
        if (bus.out_ready) begin
          if (last_win) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_FETCH;
            ras_adv = 1'b1;
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // k_q counts taps in FETCH (with one extra drain cycle) and stages in CONV.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      cap_k_q    <= '0;
      rd_pend_q  <= 1'b0;
      win_q      <= '0;
      out_data_q <= '0;
      out_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= pix_rd;
      cap_k_q   <= k_q;
      if (state_d != state_q) begin
        k_q <= '0;
      end else if (state_q == ST_FETCH || state_q == ST_CONV) begin
        k_q <= k_q + KIDX_W'(1);
      end
      if (rd_pend_q) begin
        win_q[cap_k_q] <= bus.pix_data;
      end
      if (state_q == ST_CAPT) begin
        out_data_q <= bus.conv_result;
        out_addr_q <= ras_addr;
      end
    end
  end

  assign pix_rd = (state_q == ST_FETCH) && (k_q < K_DRAIN);

  always_comb begin
    r_off    = ADDR_W'(k_q / KIDX_W'(KSIZE));
    c_off    = ADDR_W'(k_q % KIDX_W'(KSIZE));
    pix_addr = '0;
    if (pix_rd) pix_addr = (orow + r_off) * IMG_W_A + ocol + c_off;
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.pix_rd    = pix_rd;
  assign bus.pix_addr  = pix_addr;
  assign bus.win       = win_q;
  assign bus.conv_en   = (state_q == ST_CONV);
  assign bus.out_valid = (state_q == ST_OUT);
  assign bus.out_data  = out_data_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.dbg_state = state_q;

endmodule
